// File: rtl/very_half_sam_pkg.sv
// Shared widths, opcodes, state encoding and console select codes for the Very Half SAM core.
package very_half_sam_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TICK_W = 2;

  // Upper nibble of the instruction word
  localparam logic [3:0] HALT_GRP = 4'h0;
  localparam logic [3:0] BRANCH   = 4'h1;
  localparam logic [3:0] BRZERO   = 4'h2;
  localparam logic [3:0] BRPOS    = 4'h3;
  localparam logic [3:0] BRNEG    = 4'h4;
  localparam logic [3:0] BRIND    = 4'h5;
  localparam logic [3:0] CLOAD    = 4'h6;
  localparam logic [3:0] DLOAD    = 4'h7;
  localparam logic [3:0] ILOAD    = 4'h8;
  localparam logic [3:0] DSTORE   = 4'h9;
  localparam logic [3:0] ISTORE   = 4'hA;
  localparam logic [3:0] ADD      = 4'hB;
  localparam logic [3:0] ANDD     = 4'hC;

  // Field values inside the HALT_GRP opcode
  localparam logic [3:0] HALT_F   = 4'h0;
  localparam logic [3:0] NEG_F    = 4'h1;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [1:0] SEL_PC   = 2'b00;
  localparam logic [1:0] SEL_IREG = 2'b01;
  localparam logic [1:0] SEL_ACC  = 2'b10;
  localparam logic [1:0] SEL_IAR  = 2'b11;

endpackage

// File: rtl/very_half_sam_if.sv
// Memory control bus between the CPU (master) and the external synchronous memory (slave).
interface very_half_sam_if;
  import very_half_sam_pkg::*;

  logic              En;
  logic              Rw;
  logic [ADDR_W-1:0] Address_Bus;

  modport master (output En, Rw, Address_Bus);
  modport slave  (input  En, Rw, Address_Bus);
endinterface

// File: rtl/very_half_sam_cpu.sv
// Very Half SAM: 8-bit single-accumulator CPU with a tick-sequenced fetch/execute FSM.
module very_half_sam_cpu
  import very_half_sam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  very_half_sam_if.master   mem,
  inout  wire  [DATA_W-1:0] Data_Bus,
  input  logic              pause,
  input  logic [1:0]        regSelect,
  output logic [DATA_W-1:0] dispReg
);

  state_t            state, state_n;
  logic [TICK_W-1:0] tick, tick_n;
  logic [DATA_W-1:0] pc, pc_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic [DATA_W-1:0] ireg, ireg_n;
  logic [DATA_W-1:0] iar, iar_n;

  logic              en_c, rw_c, wr_c;
  logic [ADDR_W-1:0] addr_c;
  logic              done, halt_req;
  logic [3:0]        op, f;
  logic [DATA_W-1:0] fz, rdata;

  assign op    = ireg[7:4];
  assign f     = ireg[3:0];
  assign fz    = DATA_W'(f);
  assign rdata = Data_Bus;

  // State and architectural registers; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      tick  <= '0;
      pc    <= '0;
      acc   <= '0;
      ireg  <= '0;
      iar   <= '0;
    end else begin
      state <= state_n;
      tick  <= tick_n;
      pc    <= pc_n;
      acc   <= acc_n;
      ireg  <= ireg_n;
      iar   <= iar_n;
    end
  end

  // Next-state, register updates and bus decode from state/tick/registers
  always_comb begin
    state_n  = state;
    tick_n   = tick;
    pc_n     = pc;
    acc_n    = acc;
    ireg_n   = ireg;
    iar_n    = iar;
    en_c     = 1'b0;
    rw_c     = 1'b1;
    wr_c     = 1'b0;
    addr_c   = '0;
    done     = 1'b0;
    halt_req = 1'b0;

    case (state)
      FETCH: begin
        if (tick == TICK_W'(0)) begin
          // Pause only stalls here, before the instruction read is issued
          if (!pause) begin
            en_c   = 1'b1;
            addr_c = pc;
            tick_n = TICK_W'(1);
          end
        end else begin
          ireg_n  = rdata;
          pc_n    = pc + 8'd1;
          tick_n  = '0;
          state_n = EXECUTE;
        end
      end

      EXECUTE: begin
        tick_n = tick + TICK_W'(1);
        case (op)
          HALT_GRP: begin
            done = 1'b1;
            if (f == HALT_F)     halt_req = 1'b1;
            else if (f == NEG_F) acc_n    = -acc;
          end
          BRANCH: begin
            done = 1'b1;
            pc_n = pc + fz;
          end
          BRZERO: begin
            done = 1'b1;
            if (acc == '0) pc_n = pc + fz;
          end
          BRPOS: begin
            done = 1'b1;
            if (acc != '0 && !acc[DATA_W-1]) pc_n = pc + fz;
          end
          BRNEG: begin
            done = 1'b1;
            if (acc[DATA_W-1]) pc_n = pc + fz;
          end
          BRIND: begin
            if (tick == TICK_W'(0)) begin
              en_c   = 1'b1;
              addr_c = pc + fz;
            end else begin
              pc_n = rdata;
              done = 1'b1;
            end
          end
          CLOAD: begin
            done  = 1'b1;
            acc_n = fz;
          end
          DLOAD, ADD, ANDD: begin
            if (tick == TICK_W'(0)) begin
              en_c   = 1'b1;
              addr_c = fz;
            end else begin
              done = 1'b1;
              if (op == DLOAD)    acc_n = rdata;
              else if (op == ADD) acc_n = acc + rdata;
              else                acc_n = acc & rdata;
            end
          end
          ILOAD: begin
            case (tick)
              TICK_W'(0): begin en_c = 1'b1; addr_c = fz; end
              TICK_W'(1): iar_n = rdata;
              TICK_W'(2): begin en_c = 1'b1; addr_c = iar; end
              default: begin acc_n = rdata; done = 1'b1; end
            endcase
          end
          DSTORE: begin
            en_c   = 1'b1;
            rw_c   = 1'b0;
            wr_c   = 1'b1;
            addr_c = fz;
            done   = 1'b1;
          end
          ISTORE: begin
            case (tick)
              TICK_W'(0): begin en_c = 1'b1; addr_c = fz; end
              TICK_W'(1): iar_n = rdata;
              default: begin
                en_c   = 1'b1;
                rw_c   = 1'b0;
                wr_c   = 1'b1;
                addr_c = iar;
                done   = 1'b1;
              end
            endcase
          end
          default: done = 1'b1;
        endcase
        if (done) begin
          tick_n  = '0;
          state_n = halt_req ? HALT : FETCH;
        end
      end

      HALT: begin
      end

      default: begin
        state_n = FETCH;
        tick_n  = '0;
      end
    endcase
  end

  // Bus outputs; the reset cycle never issues an access or drives data
  assign mem.En          = en_c & ~rst;
  assign mem.Rw          = rw_c | rst;
  assign mem.Address_Bus = addr_c;
  assign Data_Bus        = (wr_c && !rst) ? acc : {DATA_W{1'bz}};

  // Console register view
  always_comb begin
    case (regSelect)
      SEL_PC:   dispReg = pc;
      SEL_IREG: dispReg = ireg;
      SEL_ACC:  dispReg = acc;
      default:  dispReg = iar;
    endcase
  end

endmodule

// File: tb/tb_very_half_sam_cpu.sv
// Bench for very_half_sam_cpu: memory model, instruction-level reference model, directed and random programs.
module tb_very_half_sam_cpu;

  logic       clk;
  logic       rst;
  logic       pause;
  logic [1:0] regSelect;
  logic [7:0] dispReg;
  wire  [7:0] data_bus;

  very_half_sam_if bus ();

  very_half_sam_cpu dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus),
    .Data_Bus  (data_bus),
    .pause     (pause),
    .regSelect (regSelect),
    .dispReg   (dispReg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // External memory: synchronous read (data valid the cycle after the request), write at the edge
  logic [7:0] mem [256];
  logic [7:0] rd_q;
  logic       rd_v;
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  always @(posedge clk) begin
    rd_v <= 1'b0;
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.En && bus.Rw) begin
      rd_q <= mem[bus.Address_Bus];
      rd_v <= 1'b1;
    end else if (bus.En && !bus.Rw) mem[bus.Address_Bus] <= data_bus;
  end

  assign data_bus = rd_v ? rd_q : 8'bz;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state and memory at instruction granularity
  logic [7:0] img     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] m_pc, m_acc, m_ireg, m_iar;

  typedef struct packed {
    logic       en;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wd;
  } cyc_t;
  cyc_t q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic en, input logic rw, input logic [7:0] addr, input logic [7:0] wd);
    cyc_t c;
    c.en = en; c.rw = rw; c.addr = addr; c.wd = wd;
    q.push_back(c);
  endfunction

  // Executes one instruction of the model and lists the expected bus activity cycle by cycle
  function automatic void model_step(output bit halted);
    logic [7:0] w, a, fz;
    halted = 1'b0;
    q.delete();
    w = ref_mem[m_pc];
    push(1'b1, 1'b1, m_pc, 8'h00);
    push(1'b0, 1'b1, 8'h00, 8'h00);
    m_ireg = w;
    m_pc   = m_pc + 8'd1;
    fz     = {4'h0, w[3:0]};
    case (w[7:4])
      4'h0: begin
        push(1'b0, 1'b1, 8'h00, 8'h00);
        if (w[3:0] == 4'h0)      halted = 1'b1;
        else if (w[3:0] == 4'h1) m_acc = 8'h00 - m_acc;
      end
      4'h1: begin push(1'b0, 1'b1, 8'h00, 8'h00); m_pc = m_pc + fz; end
      4'h2: begin push(1'b0, 1'b1, 8'h00, 8'h00); if (m_acc == 8'h00) m_pc = m_pc + fz; end
      4'h3: begin push(1'b0, 1'b1, 8'h00, 8'h00); if ($signed(m_acc) > 0) m_pc = m_pc + fz; end
      4'h4: begin push(1'b0, 1'b1, 8'h00, 8'h00); if ($signed(m_acc) < 0) m_pc = m_pc + fz; end
      4'h5: begin
        a = m_pc + fz;
        push(1'b1, 1'b1, a, 8'h00); push(1'b0, 1'b1, 8'h00, 8'h00);
        m_pc = ref_mem[a];
      end
      4'h6: begin push(1'b0, 1'b1, 8'h00, 8'h00); m_acc = fz; end
      4'h7, 4'hB, 4'hC: begin
        push(1'b1, 1'b1, fz, 8'h00); push(1'b0, 1'b1, 8'h00, 8'h00);
        if (w[7:4] == 4'h7)      m_acc = ref_mem[fz];
        else if (w[7:4] == 4'hB) m_acc = m_acc + ref_mem[fz];
        else                     m_acc = m_acc & ref_mem[fz];
      end
      4'h8: begin
        push(1'b1, 1'b1, fz, 8'h00); push(1'b0, 1'b1, 8'h00, 8'h00);
        m_iar = ref_mem[fz];
        push(1'b1, 1'b1, m_iar, 8'h00); push(1'b0, 1'b1, 8'h00, 8'h00);
        m_acc = ref_mem[m_iar];
      end
      4'h9: begin push(1'b1, 1'b0, fz, m_acc); ref_mem[fz] = m_acc; end
      4'hA: begin
        push(1'b1, 1'b1, fz, 8'h00); push(1'b0, 1'b1, 8'h00, 8'h00);
        m_iar = ref_mem[fz];
        push(1'b1, 1'b0, m_iar, m_acc);
        ref_mem[m_iar] = m_acc;
      end
      default: push(1'b0, 1'b1, 8'h00, 8'h00);
    endcase
  endfunction

  task automatic check_console(input string where);
    logic [7:0] exp [4];
    exp[0] = m_pc; exp[1] = m_ireg; exp[2] = m_acc; exp[3] = m_iar;
    for (int s = 0; s < 4; s++) begin
      regSelect = 2'(s);
      #1;
      chk($sformatf("%s_disp%0d", where, s), dispReg, exp[s]);
    end
  endtask

  task automatic peek(input logic [1:0] sel, input string tag, input logic [7:0] exp);
    regSelect = sel;
    #1;
    chk(tag, dispReg, exp);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    pause = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("rst_en", 8'(bus.En), 8'h00);
    chk("rst_rw", 8'(bus.Rw), 8'h01);
    next_cycle();
    rst    = 1'b0;
    m_pc   = 8'h00;
    m_acc  = 8'h00;
    m_ireg = 8'h00;
    m_iar  = 8'h00;
  endtask

  // Writes img into the memory model while the core is held in reset, then releases reset
  task automatic load_image();
    rst   = 1'b1;
    pause = 1'b0;
    for (int a = 0; a < 256; a++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      ld_data = img[a];
      next_cycle();
    end
    ld_en = 1'b0;
    for (int a = 0; a < 256; a++) ref_mem[a] = img[a];
    do_reset();
  endtask

  task automatic clear_image();
    for (int a = 0; a < 256; a++) img[a] = 8'h00;
  endtask

  // Runs up to max_instr instructions, checking every bus cycle and the console at each boundary
  task automatic run_program(input int max_instr, output bit halted);
    cyc_t c;
    int   stalls;
    halted = 1'b0;
    for (int n = 0; n < max_instr && !halted; n++) begin
      check_console("boundary");
      stalls = 0;
      while (stalls < 3 && $urandom_range(0, 3) == 0) begin
        pause = 1'b1;
        @(negedge clk);
        chk("pause_en", 8'(bus.En), 8'h00);
        next_cycle();
        stalls++;
      end
      pause = 1'b0;
      model_step(halted);
      for (int i = 0; i < q.size(); i++) begin
        c = q[i];
        if (i > 0) pause = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk($sformatf("pc%02h_c%0d_en", m_pc, i), 8'(bus.En), 8'(c.en));
        chk($sformatf("pc%02h_c%0d_rw", m_pc, i), 8'(bus.Rw), 8'(c.rw));
        if (c.en) chk($sformatf("pc%02h_c%0d_addr", m_pc, i), bus.Address_Bus, c.addr);
        if (c.en && !c.rw) chk($sformatf("pc%02h_c%0d_wdata", m_pc, i), data_bus, c.wd);
        next_cycle();
      end
      pause = 1'b0;
    end
    if (halted) begin
      for (int k = 0; k < 3; k++) begin
        pause = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("halt_en", 8'(bus.En), 8'h00);
        next_cycle();
      end
      pause = 1'b0;
      check_console("halted");
    end
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 256; a++) chk($sformatf("%s_m%02h", tag, a), mem[a], ref_mem[a]);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    rst = 1'b1; pause = 1'b0; regSelect = 2'b00;
    ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;

    // Branch chain: fetches 0, 8, 16, 19; halt at 19 leaves PC=0x14
    clear_image();
    img[0] = 8'h17; img[8] = 8'h17; img[16] = 8'h12;
    load_image();
    check_console("reset");
    run_program(20, h);
    chk("chain_halted", 8'(h), 8'h01);
    peek(2'b00, "chain_pc", 8'h14);

    // cload/andd/dstore/iload
    clear_image();
    img[0] = 8'h1F; img[1] = 8'h61; img[2] = 8'h01; img[3] = 8'h02;
    img[16] = 8'h63; img[17] = 8'hC1; img[18] = 8'h94; img[19] = 8'h82; img[20] = 8'h00;
    load_image();
    run_program(20, h);
    chk("alu_halted", 8'(h), 8'h01);
    peek(2'b10, "alu_acc", 8'h61);
    peek(2'b11, "alu_iar", 8'h01);
    chk("alu_m4", mem[4], 8'h01);
    check_mem("alu");

    // negate twice: 3 -> 0xFD -> 3
    clear_image();
    img[0] = 8'h63; img[1] = 8'h01; img[2] = 8'h01; img[3] = 8'h00;
    load_image();
    run_program(20, h);
    peek(2'b10, "neg_acc", 8'h03);
    peek(2'b00, "neg_pc", 8'h04);

    // istore through M[15] and brInd at 47 via M[56]
    clear_image();
    img[0] = 8'h65; img[1] = 8'hAF; img[15] = 8'h06; img[2] = 8'h1F;
    img[18] = 8'h1F; img[34] = 8'h1C; img[47] = 8'h58; img[56] = 8'h21; img[33] = 8'h00;
    load_image();
    run_program(20, h);
    chk("ind_halted", 8'(h), 8'h01);
    chk("ind_m6", mem[6], 8'h05);
    peek(2'b00, "ind_pc", 8'h22);
    check_mem("ind");

    // Reset during the IAR read of an iload
    clear_image();
    img[0] = 8'h6A; img[1] = 8'h85; img[5] = 8'h07; img[7] = 8'h44;
    load_image();
    run_program(1, h);
    for (int k = 0; k < 4; k++) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_iload_en", 8'(bus.En), 8'h00);
    next_cycle();
    rst = 1'b0;
    m_pc = 8'h00; m_acc = 8'h00; m_ireg = 8'h00; m_iar = 8'h00;
    check_console("after_rst");
    @(negedge clk);
    chk("after_rst_en", 8'(bus.En), 8'h01);
    chk("after_rst_addr", bus.Address_Bus, 8'h00);
    next_cycle();

    // Reset during the write cycle of an istore: no write reaches memory
    clear_image();
    img[0] = 8'h67; img[1] = 8'hA9; img[9] = 8'h30; img[8'h30] = 8'h55;
    load_image();
    run_program(1, h);
    for (int k = 0; k < 4; k++) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_istore_en", 8'(bus.En), 8'h00);
    chk("rst_istore_rw", 8'(bus.Rw), 8'h01);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    chk("rst_istore_mem", mem[8'h30], 8'h55);
    peek(2'b10, "rst_istore_acc", 8'h00);

    // Random programs with random pause activity against the reference model
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 256; a++)
        img[a] = ($urandom_range(0, 19) == 0) ? 8'h00 : 8'($urandom);
      load_image();
      run_program(120, h);
      check_mem($sformatf("rand%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/very_half_sam_cpu.md
Name: very_half_sam_cpu

Overview:
- 8-bit single-accumulator processor ("Very Half SAM") with 8-bit instructions: 4-bit opcode plus 4-bit field.
- Talks to an external synchronous memory through en/rw/address/data.
- Exposes a console for pausing and for viewing internal registers.
- Top-level CPU block; the memory model and console sit outside it.

Parameters:
- None. Data, address and instruction width are fixed at 8 bits.

Ports:
- clk  in  1  system clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- En  out  1  memory access enable.
- Rw  out  1  1 = read, 0 = write; held at 1 when idle.
- Address_Bus  out  8  memory address.
- Data_Bus  inout  8  driven by the CPU only during write cycles, otherwise high-Z.
- pause  in  1  console pause request.
- regSelect  in  2  console register select: 00 PC, 01 IREG, 10 ACC, 11 IAR.
- dispReg  out  8  selected register, combinational.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: PC=0, ACC=0, IREG=0, IAR=0, state=FETCH, En=0, Rw=1, Data_Bus=Z.
- Memory timing:
  - Read: En=1, Rw=1 with the address in cycle t; data is valid on Data_Bus during cycle t+1 and is captured at the end of t+1 (2 cycles per read).
  - Write: En=1, Rw=0, address and Data_Bus driven in one cycle; memory captures at that edge.
- En, Rw and Address_Bus are decoded from state, tick and registers.
- FETCH (2 cycles):
  - Tick 0: if pause=1, hold FETCH with En=0; otherwise issue a read at PC.
  - Tick 1: IREG<=data, PC<=PC+1, go to EXECUTE.
- In EXECUTE, "PC" means the already-incremented PC.
- f is IREG[3:0]. Direct addresses are f zero-extended. Branch target is PC+f (mod 256); f is unsigned, so branches are forward only.

Instruction table (opcode = IREG[7:4]):
- 0x00 halt: enter HALT. No further bus activity until rst. The console stays live.
- 0x01 negate: ACC <= -ACC (two's complement).
- 0x02-0x0F: no-op.
- 1 branch: PC <= PC+f.
- 2 brZero: branch if ACC==0.
- 3 brPos: branch if ACC!=0 and ACC[7]=0.
- 4 brNeg: branch if ACC[7]=1.
- 5 brInd: read M[PC+f], then PC <= that value.
- 6 cload: ACC <= {4'b0,f}.
- 7 dload: ACC <= M[f].
- 8 iload: IAR <= M[f], then ACC <= M[IAR].
- 9 dstore: M[f] <= ACC.
- A istore: IAR <= M[f], then write ACC to M[IAR].
- B add: ACC <= ACC+M[f], mod 256, no flags.
- C andd: ACC <= ACC & M[f].
- D-F: no-op.

EXECUTE cycle counts, then return to FETCH:
- 1 cycle: halt, negate, cload, branch, conditional branches (taken or not), no-ops, dstore.
- 2 cycles: dload, add, andd, brInd.
- 3 cycles: istore.
- 4 cycles: iload.

Other rules:
- Self-modifying code is legal: stores to later instruction words take effect when those words are fetched.
- pause is honoured only at the FETCH boundary; an in-flight instruction always completes.
- rst mid-instruction aborts it immediately; no write is issued in the reset cycle.
- HALT ignores pause.
- After halt, PC points to the halt address + 1.

Decomposition:
- Package very_half_sam_pkg:
  - 4-bit opcode constants: HALT_GRP, BRANCH, BRZERO, BRPOS, BRNEG, BRIND, CLOAD, DLOAD, ILOAD, DSTORE, ISTORE, ADD, ANDD.
  - State enum: FETCH, EXECUTE, HALT.
  - Console select codes.
- Single module; a 2-bit tick counter drives sequencing. No sub-module is needed.

Test Plan:
- Reset/branch chain: M[0]=0x17, M[8]=0x17, M[16]=0x12 -> fetch addresses 0, 8, 16, 19 in sequence; PC=0x14 after the fetch at 19.
- ALU/direct ops: M[1]=0x61, M[3]=2; run cload #3, andd 1, dstore 4 -> write of 1 to address 4; then iload 2 (M[2]=1) -> ACC=0x61.
- negate/console: ACC=0xFD, execute 0x01 -> regSelect=10 shows 0x03; regSelect=01 shows 0x01.
- Indirect + brInd: istore 0xAF with M[15]=6 -> write to address 6; brInd 0x58 at address 47 with M[56]=0x21 -> next fetch at 33.
- Full 64-word demo program (branch chain, sum loop, self-modification) -> halts at 54 with M[13]=13, M[8]=5, M[9]=8, M[10]=13, M[12]=10, M[15]=9, ACC=0xF6, PC=0x37; En stays 0 afterwards.
- pause held high during a loop -> En stays 0 at the FETCH boundary; release -> execution resumes at the same PC with no lost or duplicated instruction. rst asserted mid-iload -> PC=0, ACC=0, fetch from 0 next.
